// File: rtl/ws2812_frame_ctl.sv
// ws2812_frame_ctl: frame sequencer feeding a WS2812 single-bit encoder.
// Reads pixel_num_in 24-bit words from a synchronous pixel RAM and sends
// each one MSB-first, one bit_rdy_out/bit_done_in handshake per bit. After
// the last bit it holds the line low for RST_CNT cycles (the latch gap),
// then pulses frame_done_out.
// Optional feature macro: WS2812_FRAME_CTL_GRB_EN. When defined, each RAM
// word {R,G,B} is reordered to {G,R,B} on load, giving native WS2812 wire
// order. When undefined, the wire order equals the RAM order.
module ws2812_frame_ctl #(
    parameter int ADDR_W  = 8,
    parameter int RST_CNT = 16000,
    parameter int RST_W   = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              frame_start_in,
    input  logic [ADDR_W-1:0] pixel_num_in,
    output logic              pix_rd_en_out,
    output logic [ADDR_W-1:0] pix_rd_addr_out,
    input  logic [23:0]       pix_rd_data_in,
    output logic              bit_rdy_out,
    output logic              bit_data_out,
    input  logic              bit_done_in,
    output logic              frame_busy_out,
    output logic              frame_done_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [4:0]        r_bitCnt;
    logic [RST_W-1:0]  r_gapCnt;
    logic [23:0]       r_shreg;
    logic [23:0]       w_loadWord;

    // RAM word as it should appear on the wire, optionally reordered to GRB
`ifdef WS2812_FRAME_CTL_GRB_EN
    assign w_loadWord = {pix_rd_data_in[15:8], pix_rd_data_in[23:16], pix_rd_data_in[7:0]};
`else
    assign w_loadWord = pix_rd_data_in;
`endif

    // Frame FSM; every output is registered and set on entry to the state that owns it
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state         <= S_IDLE;
            r_count         <= '0;
            r_idx           <= '0;
            r_bitCnt        <= '0;
            r_gapCnt        <= '0;
            r_shreg         <= '0;
            pix_rd_en_out   <= 1'b0;
            pix_rd_addr_out <= '0;
            bit_rdy_out     <= 1'b0;
            bit_data_out    <= 1'b0;
            frame_busy_out  <= 1'b0;
            frame_done_out  <= 1'b0;
        end else begin
            pix_rd_en_out  <= 1'b0;
            bit_rdy_out    <= 1'b0;
            frame_done_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start_in) begin
                        if (pixel_num_in == '0) begin
                            frame_done_out <= 1'b1;
                        end else begin
                            r_count         <= pixel_num_in;
                            r_idx           <= '0;
                            pix_rd_en_out   <= 1'b1;
                            pix_rd_addr_out <= '0;
                            frame_busy_out  <= 1'b1;
                            r_state         <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shreg      <= w_loadWord;
                    r_bitCnt     <= 5'd23;
                    bit_rdy_out  <= 1'b1;
                    bit_data_out <= w_loadWord[23];
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bit_done_in) begin
                        if (r_bitCnt != 5'd0) begin
                            r_shreg      <= {r_shreg[22:0], 1'b0};
                            r_bitCnt     <= r_bitCnt - 5'd1;
                            bit_rdy_out  <= 1'b1;
                            bit_data_out <= r_shreg[22];
                            r_state      <= S_SEND;
                        end else if (r_idx < (r_count - ADDR_W'(1))) begin
                            r_idx           <= r_idx + ADDR_W'(1);
                            pix_rd_en_out   <= 1'b1;
                            pix_rd_addr_out <= r_idx + ADDR_W'(1);
                            r_state         <= S_FETCH;
                        end else begin
                            r_gapCnt     <= '0;
                            bit_data_out <= 1'b0;
                            r_state      <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gapCnt == RST_W'(RST_CNT - 1)) begin
                        frame_done_out <= 1'b1;
                        frame_busy_out <= 1'b0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + RST_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_ctl.sv
// tb_ws2812_frame_ctl: self-checking bench for ws2812_frame_ctl.
// Frame table drives whole frames; expected RAM addresses, wire bits and
// inter-bit gaps are queued at stimulus time and popped as the DUT emits them.
// Honours WS2812_FRAME_CTL_GRB_EN for the expected wire order.
module tb_ws2812_frame_ctl;

    localparam int ADDR_W  = 8;
    localparam int RST_CNT = 40;
    localparam int RST_W   = 16;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              frame_start_in;
    logic [ADDR_W-1:0] pixel_num_in;
    logic              pix_rd_en_out;
    logic [ADDR_W-1:0] pix_rd_addr_out;
    logic [23:0]       pix_rd_data_in;
    logic              bit_rdy_out;
    logic              bit_data_out;
    logic              bit_done_in;
    logic              frame_busy_out;
    logic              frame_done_out;

    ws2812_frame_ctl #(
        .ADDR_W (ADDR_W),
        .RST_CNT(RST_CNT),
        .RST_W  (RST_W)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .frame_start_in (frame_start_in),
        .pixel_num_in   (pixel_num_in),
        .pix_rd_en_out  (pix_rd_en_out),
        .pix_rd_addr_out(pix_rd_addr_out),
        .pix_rd_data_in (pix_rd_data_in),
        .bit_rdy_out    (bit_rdy_out),
        .bit_data_out   (bit_data_out),
        .bit_done_in    (bit_done_in),
        .frame_busy_out (frame_busy_out),
        .frame_done_out (frame_done_out)
    );

    // 10 ns clock
    always #5 clk_in = ~clk_in;

    typedef struct {
        int               num;
        logic [2:0][23:0] ramWords;
        logic [2:0][23:0] wireWords;
    } frameVec_t;

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   bitCount, readCount, doneCount;
    int   firstRdyCycle, lastDoneCycle, doneCycle, startCycle;
    int   busyBeforeDone;
    int   resetEpoch = 0;
    int   prevBusy = 0;
    logic [23:0] ram [0:255];
    logic        ramPending = 1'b0;
    logic [ADDR_W-1:0] ramAddr = '0;
    int   expAddrQ[$];
    int   expGapQ[$];
    logic expBitQ[$];

    // Cycle index; at a negedge it names the cycle currently in progress
    always @(posedge clk_in) cycle++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic int outVec();
        return int'({pix_rd_en_out, pix_rd_addr_out, bit_rdy_out, bit_data_out,
                     frame_busy_out, frame_done_out});
    endfunction

    // RAM model (1-cycle read latency), read-address scoreboard and done monitor
    initial begin
        forever begin
            @(negedge clk_in);
            if (frame_done_out === 1'b1) begin
                doneCount++;
                doneCycle = cycle;
                busyBeforeDone = prevBusy;
                checkOutput("busyLowAtDone", int'(frame_busy_out), 0);
            end
            if (pix_rd_en_out === 1'b1) begin
                readCount++;
                if (expAddrQ.size() == 0) checkOutput("unexpectedRead", int'(pix_rd_addr_out), -1);
                else checkOutput("readAddr", int'(pix_rd_addr_out), expAddrQ.pop_front());
            end
            if (ramPending) pix_rd_data_in = ram[ramAddr];
            else            pix_rd_data_in = 24'h5A5A5A;
            ramPending = pix_rd_en_out;
            ramAddr    = pix_rd_addr_out;
            prevBusy   = int'(frame_busy_out);
        end
    end

    // Encoder model: bit_done_in 4 cycles after each bit_rdy_out, checks bits on the way
    initial begin
        int   myEpoch;
        int   expGap;
        logic expBit;
        bit_done_in = 1'b0;
        forever begin
            @(negedge clk_in);
            bit_done_in = 1'b0;
            if (bit_rdy_out === 1'b1 && !rst_in) begin
                bitCount++;
                if (firstRdyCycle < 0) firstRdyCycle = cycle;
                myEpoch = resetEpoch;
                expBit  = 1'b0;
                if (expBitQ.size() == 0) begin
                    checkOutput("unexpectedBit", int'(bit_data_out), -1);
                end else begin
                    expBit = expBitQ.pop_front();
                    expGap = expGapQ.pop_front();
                    checkOutput("bitValue", int'(bit_data_out), int'(expBit));
                    if (expGap >= 0) checkOutput("interBitGap", cycle - lastDoneCycle, expGap);
                end
                for (int w = 0; w < 4; w++) begin
                    @(negedge clk_in);
                    if (resetEpoch == myEpoch && !rst_in) begin
                        checkOutput("bitStable", int'(bit_data_out), int'(expBit));
                        if (w == 0) checkOutput("rdyPulseWidth", int'(bit_rdy_out), 0);
                    end
                end
                bit_done_in   = 1'b1;
                lastDoneCycle = cycle;
            end
        end
    end

    // Load RAM, queue the expected reads/bits/gaps and pulse frame_start_in
    task automatic applyStimulus(input int num, input logic [2:0][23:0] ramWords,
                                 input logic [2:0][23:0] wireWords);
        logic [23:0] w;
        for (int i = 0; i < num && i < 3; i++) ram[i] = ramWords[i];
        for (int p = 0; p < num; p++) begin
            expAddrQ.push_back(p);
            w = wireWords[p];
            for (int b = 23; b >= 0; b--) begin
                expBitQ.push_back(w[b]);
                expGapQ.push_back((b != 23) ? 1 : ((p == 0) ? -1 : 3));
            end
        end
        bitCount = 0; readCount = 0; doneCount = 0;
        firstRdyCycle = -1; lastDoneCycle = -1; doneCycle = -1; busyBeforeDone = -1;
        pixel_num_in   = ADDR_W'(num);
        frame_start_in = 1'b1;
        startCycle     = cycle;
        @(negedge clk_in);
        frame_start_in = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int  n  = 0;
        bit  ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk_in);
            n++;
            if (doneCount > 0) ok = 1'b1;
        end
        if (!ok) checkOutput("doneTimeout", doneCount, 1);
    endtask

    task automatic waitBits(input int target, input int budget);
        int n = 0;
        while (n < budget && bitCount < target) begin
            @(negedge clk_in);
            n++;
        end
        if (bitCount < target) checkOutput("bitTimeout", bitCount, target);
    endtask

    task automatic pulseStart(input int num);
        pixel_num_in   = ADDR_W'(num);
        frame_start_in = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
    endtask

    // Absolute time limit so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frameVec_t vecs[4];

        vecs[0].num = 1; vecs[0].ramWords = {24'h0, 24'h0, 24'hA50F81};
        vecs[1].num = 3; vecs[1].ramWords = {24'h778899, 24'h445566, 24'h112233};
        vecs[2].num = 0; vecs[2].ramWords = {24'h0, 24'h0, 24'h0};
        vecs[3].num = 2; vecs[3].ramWords = {24'h0, 24'hFF00FF, 24'h800001};
`ifdef WS2812_FRAME_CTL_GRB_EN
        vecs[0].wireWords = {24'h0, 24'h0, 24'h0FA581};
        vecs[1].wireWords = {24'h887799, 24'h554466, 24'h221133};
        vecs[2].wireWords = {24'h0, 24'h0, 24'h0};
        vecs[3].wireWords = {24'h0, 24'h00FFFF, 24'h008001};
`else
        vecs[0].wireWords = {24'h0, 24'h0, 24'hA50F81};
        vecs[1].wireWords = {24'h778899, 24'h445566, 24'h112233};
        vecs[2].wireWords = {24'h0, 24'h0, 24'h0};
        vecs[3].wireWords = {24'h0, 24'hFF00FF, 24'h800001};
`endif

        rst_in = 1'b1; frame_start_in = 1'b0; pixel_num_in = '0;
        bitCount = 0; readCount = 0; doneCount = 0;
        firstRdyCycle = -1; lastDoneCycle = -1; doneCycle = -1;

        // Reset for 2 cycles, then idle for 10 with everything low
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            checkOutput("idleOutputs", outVec(), 0);
        end
        checkOutput("idleNoReads", readCount, 0);

        // Table-driven frames
        for (int k = 0; k < 4; k++) begin
            applyStimulus(vecs[k].num, vecs[k].ramWords, vecs[k].wireWords);
            waitDone(4000);
            repeat (10) @(negedge clk_in);
            checkOutput($sformatf("frame%0d_doneCount", k), doneCount, 1);
            checkOutput($sformatf("frame%0d_bits", k), bitCount, vecs[k].num * 24);
            checkOutput($sformatf("frame%0d_reads", k), readCount, vecs[k].num);
            checkOutput($sformatf("frame%0d_bitsLeft", k), expBitQ.size(), 0);
            if (vecs[k].num > 0) begin
                checkOutput($sformatf("frame%0d_latency", k), firstRdyCycle - startCycle, 3);
                checkOutput($sformatf("frame%0d_gapLen", k), doneCycle - lastDoneCycle, RST_CNT + 1);
                checkOutput($sformatf("frame%0d_busyBeforeDone", k), busyBeforeDone, 1);
            end else begin
                checkOutput($sformatf("frame%0d_zeroDoneLat", k), doneCycle - startCycle, 1);
                checkOutput($sformatf("frame%0d_zeroNoBits", k), firstRdyCycle, -1);
                checkOutput($sformatf("frame%0d_zeroBusy", k), busyBeforeDone, 0);
            end
        end

        // Start requests during WAIT and during GAP of a 2-pixel frame are ignored
        applyStimulus(2, vecs[3].ramWords, vecs[3].wireWords);
        waitBits(3, 200);
        @(negedge clk_in);
        pulseStart(1);
        waitBits(48, 1000);
        repeat (8) @(negedge clk_in);
        pulseStart(1);
        waitDone(400);
        repeat (60) @(negedge clk_in);
        checkOutput("busyStart_doneCount", doneCount, 1);
        checkOutput("busyStart_bits", bitCount, 48);
        checkOutput("busyStart_reads", readCount, 2);

        // Reset during pixel 1 bit 10, then a clean 1-pixel frame
        applyStimulus(2, vecs[3].ramWords, vecs[3].wireWords);
        waitBits(35, 1000);
        resetEpoch++;
        rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("midReset_outputs0", outVec(), 0);
        @(negedge clk_in);
        checkOutput("midReset_outputs1", outVec(), 0);
        rst_in = 1'b0;
        expBitQ.delete(); expGapQ.delete(); expAddrQ.delete();
        repeat (12) @(negedge clk_in);
        checkOutput("midReset_noDone", doneCount, 0);
        checkOutput("midReset_idle", outVec(), 0);
        applyStimulus(1, vecs[0].ramWords, vecs[0].wireWords);
        waitDone(1000);
        repeat (10) @(negedge clk_in);
        checkOutput("afterReset_doneCount", doneCount, 1);
        checkOutput("afterReset_bits", bitCount, 24);
        checkOutput("afterReset_reads", readCount, 1);
        checkOutput("afterReset_latency", firstRdyCycle - startCycle, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_ctl.md
Name: ws2812_frame_ctl

Overview:
- Frame sequencer for the WS2812 single-bit encoder (bit_rdy/bit_data in, bit_done out).
- Reads N pixel words from a synchronous pixel RAM and serialises each 24-bit word MSB-first, one encoder handshake per bit.
- Appends the latch/reset low gap after the last bit, then reports frame completion.
- Sits between the frame buffer and the encoder; one instance per LED strip.

Parameters:
- ADDR_W, 8: pixel address width; max strip length 2^ADDR_W - 1 pixels.
- RST_CNT, 16000: reset-gap length in clk_in cycles (80 us at 200 MHz).
- RST_W, 16: reset-gap counter width; must satisfy RST_CNT < 2^RST_W.

Ports:
- clk_in  in  1  system clock, 200 MHz, same clock as the encoder.
- rst_in  in  1  synchronous active-high reset.
- frame_start_in  in  1  single-cycle request to send a frame; honoured only in IDLE.
- pixel_num_in  in  ADDR_W  pixel count, sampled on an accepted frame_start_in.
- pix_rd_en_out  out  1  pixel RAM read strobe.
- pix_rd_addr_out  out  ADDR_W  pixel RAM address.
- pix_rd_data_in  in  24  RAM data {R,G,B}; valid exactly 1 cycle after pix_rd_en_out.
- bit_rdy_out  out  1  single-cycle pulse that starts one encoder bit.
- bit_data_out  out  1  current bit value; held stable from the bit_rdy_out pulse until bit_done_in.
- bit_done_in  in  1  encoder bit-complete pulse.
- frame_busy_out  out  1  high in every state except IDLE.
- frame_done_out  out  1  single-cycle pulse at the end of a frame.

Behaviour:
- Reset: all outputs 0; state IDLE; pixel counter, bit counter, gap counter and shift register cleared.
- States: IDLE, FETCH, LOAD, SEND, WAIT, GAP.
- IDLE:
  - frame_start_in=1 with pixel_num_in=0: go to no state change, but pulse frame_done_out the next cycle; no RAM reads, no bits, no gap.
  - frame_start_in=1 with pixel_num_in>0: latch the count, clear the pixel index, go to FETCH.
- FETCH (1 cycle): pix_rd_en_out=1, pix_rd_addr_out=pixel index; go to LOAD.
- LOAD (1 cycle): latch pix_rd_data_in into the 24-bit shift register, after any optional reorder; bit counter=23; go to SEND.
- SEND (1 cycle): bit_rdy_out=1, bit_data_out=shreg[23]; go to WAIT.
- WAIT: hold bit_data_out until bit_done_in=1, then:
  - bit counter>0: shift left by 1, decrement the counter, go to SEND.
  - bit counter=0 and pixel index<count-1: increment the index, go to FETCH.
  - otherwise: clear the gap counter, go to GAP.
- GAP: bit_data_out=0, no bit_rdy_out; increment the gap counter each cycle. When it reaches RST_CNT-1, pulse frame_done_out and return to IDLE, giving exactly RST_CNT cycles in GAP.
- frame_start_in outside IDLE: ignored, never queued.
- bit_done_in outside WAIT: ignored.
- Latency, accepted start to first bit_rdy_out: 3 cycles (FETCH, LOAD, SEND).
- Inter-bit gap, bit_done_in to next bit_rdy_out:
  - within a pixel: 1 cycle;
  - across pixels: 3 cycles.
- Pixel index wraps never: the count bounds it; pixel_num_in = 2^ADDR_W-1 addresses 0 to 2^ADDR_W-2.
- pix_rd_addr_out holds its last value outside FETCH.
- rst_in mid-frame: immediate return to IDLE with all outputs 0, with no frame_done_out pulse. Any encoder bit in flight completes on its own; its bit_done_in is ignored.

Optional Feature:
- Macro: WS2812_FRAME_CTL_GRB_EN.
- Defined: LOAD reorders the RAM word {R,G,B} to {G,R,B} before shifting, so the wire order is G7..G0, R7..R0, B7..B0, as native WS2812 expects.
- Undefined: the RAM word is shifted unmodified, so the wire order equals the RAM order.

Test Plan:
- Reset then idle: rst_in high 2 cycles, then low 10 cycles -> all outputs 0, no pix_rd_en_out.
- Single pixel, macro undefined: pixel_num_in=1, RAM[0]=24'hA5_0F_81, bench encoder returns bit_done_in 4 cycles after each bit_rdy_out:
  - 24 bit_rdy_out pulses carrying bits 101001010000111110000001 MSB-first;
  - bit_data_out stable within each bit;
  - then exactly RST_CNT cycles of GAP and one frame_done_out pulse;
  - frame_busy_out falls in the same cycle as that pulse.
- Three pixels, macro defined: pixel_num_in=3, RAM[0..2]=24'h112233, 24'h445566, 24'h778899:
  - wire words 24'h221133, 24'h554466, 24'h887799;
  - addresses 0, 1, 2, each read once;
  - 3-cycle gap between bit_done_in and bit_rdy_out at pixel boundaries.
- Zero length: pixel_num_in=0 with frame_start_in -> frame_done_out pulse 1 cycle later, no RAM reads, no bit_rdy_out.
- Start while busy: frame_start_in asserted during WAIT and during GAP of a 2-pixel frame -> ignored; exactly 48 bits and one frame_done_out.
- Reset mid-frame: rst_in during pixel 1 bit 10, then start a new 1-pixel frame -> outputs 0 during reset, no frame_done_out; the new frame starts at address 0 with a clean 24-bit sequence.
